// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared integer-pipeline constants and write-back source type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int XLEN       = 64;
  localparam int NREGS      = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_MEM  = 2'd2,
    WB_MDU  = 2'd3
  } wb_src_e;

endpackage

`default_nettype wire

// File: rtl/wb_scoreboard.sv
// ============================================================================
// Module      : wb_scoreboard
// Description : Register busy bits, set at issue and cleared at commit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_scoreboard
  import cpu_pkg::*;
#(
  parameter int NREGS = cpu_pkg::NREGS
) (
  input  logic                  clk,
  input  logic                  rst_sync,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_rd,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_rd,
  output logic [NREGS-1:0]      busy
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_next;

  // Clear is applied before set so a same-cycle set/clear of one register leaves it busy.
  always_comb begin
    w_busy_next = r_busy;
    if (clr_en) begin
      w_busy_next[clr_rd] = 1'b0;
    end
    if (set_en) begin
      w_busy_next[set_rd] = 1'b1;
    end
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  assign busy = r_busy;

endmodule

`default_nettype wire

// File: rtl/writeback_unit.sv
// ============================================================================
// Module      : writeback_unit
// Description : Arbitrates ALU/MEM/MDU results onto the regfile write port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module writeback_unit
  import cpu_pkg::*;
#(
  parameter int XLEN  = cpu_pkg::XLEN,
  parameter int NREGS = cpu_pkg::NREGS
) (
  input  logic                  clk,
  input  logic                  rst_sync,
  input  logic                  issue_valid_i,
  input  logic [REG_ADDR_W-1:0] issue_rd_i,
  input  logic                  alu_valid_i,
  input  logic [REG_ADDR_W-1:0] alu_rd_i,
  input  logic [XLEN-1:0]       alu_data_i,
  input  logic                  mem_valid_i,
  output logic                  mem_ready_o,
  input  logic [REG_ADDR_W-1:0] mem_rd_i,
  input  logic [XLEN-1:0]       mem_data_i,
  input  logic                  mdu_valid_i,
  output logic                  mdu_ready_o,
  input  logic [REG_ADDR_W-1:0] mdu_rd_i,
  input  logic [XLEN-1:0]       mdu_data_i,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  output logic                  wr_en_o,
  output logic [XLEN-1:0]       rd_data_o,
  output logic [NREGS-1:0]      busy_o
);

  wb_src_e               r_rr_turn;
  logic                  r_wr_en;
  logic [REG_ADDR_W-1:0] r_rd_addr;
  logic [XLEN-1:0]       r_rd_data;

  logic                  w_mem_grant;
  logic                  w_mdu_grant;
  wb_src_e               w_sel;
  logic [REG_ADDR_W-1:0] w_rd;
  logic [XLEN-1:0]       w_data;

  // ALU never stalls, so the slow sources only compete when it is idle.
  always_comb begin
    w_mem_grant = 1'b0;
    w_mdu_grant = 1'b0;
    if (!alu_valid_i) begin
      w_mem_grant = mem_valid_i && (!mdu_valid_i || (r_rr_turn == WB_MEM));
      w_mdu_grant = mdu_valid_i && (!mem_valid_i || (r_rr_turn == WB_MDU));
    end
  end

  assign mem_ready_o = w_mem_grant;
  assign mdu_ready_o = w_mdu_grant;

  always_comb begin
    w_sel  = WB_NONE;
    w_rd   = '0;
    w_data = '0;
    if (alu_valid_i) begin
      w_sel  = WB_ALU;
      w_rd   = alu_rd_i;
      w_data = alu_data_i;
    end else if (w_mem_grant) begin
      w_sel  = WB_MEM;
      w_rd   = mem_rd_i;
      w_data = mem_data_i;
    end else if (w_mdu_grant) begin
      w_sel  = WB_MDU;
      w_rd   = mdu_rd_i;
      w_data = mdu_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      r_wr_en   <= 1'b0;
      r_rd_addr <= '0;
      r_rd_data <= '0;
      r_rr_turn <= WB_MEM;
    end else begin
      r_wr_en <= (w_sel != WB_NONE) && (w_rd != '0);
      if (w_sel != WB_NONE) begin
        r_rd_addr <= w_rd;
        r_rd_data <= w_data;
      end
      if (w_sel == WB_MEM) begin
        r_rr_turn <= WB_MDU;
      end else if (w_sel == WB_MDU) begin
        r_rr_turn <= WB_MEM;
      end
    end
  end

  assign wr_en_o   = r_wr_en;
  assign rd_addr_o = r_rd_addr;
  assign rd_data_o = r_rd_data;

  wb_scoreboard #(
    .NREGS (NREGS)
  ) u_scoreboard (
    .clk      (clk),
    .rst_sync (rst_sync),
    .set_en   (issue_valid_i && (issue_rd_i != '0)),
    .set_rd   (issue_rd_i),
    .clr_en   (r_wr_en),
    .clr_rd   (r_rd_addr),
    .busy     (busy_o)
  );

  a_alu_busy : assert property (@(posedge clk) disable iff (rst_sync)
    (alu_valid_i && (alu_rd_i != '0)) |-> busy_o[alu_rd_i]);
  a_mem_busy : assert property (@(posedge clk) disable iff (rst_sync)
    (mem_valid_i && (mem_rd_i != '0)) |-> busy_o[mem_rd_i]);
  a_mdu_busy : assert property (@(posedge clk) disable iff (rst_sync)
    (mdu_valid_i && (mdu_rd_i != '0)) |-> busy_o[mdu_rd_i]);
  // A register committing this cycle is free again for a new issue.
  a_no_waw : assert property (@(posedge clk) disable iff (rst_sync)
    (issue_valid_i && (issue_rd_i != '0)) |->
      (!busy_o[issue_rd_i] || (wr_en_o && (rd_addr_o == issue_rd_i))));

endmodule

`default_nettype wire

// File: tb/tb_writeback_unit.sv
// ============================================================================
// Module      : tb_writeback_unit
// Description : Directed self-checking bench for writeback_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_writeback_unit;
  import cpu_pkg::*;

  logic                  clk;
  logic                  rst_sync;
  logic                  issue_valid_i;
  logic [REG_ADDR_W-1:0] issue_rd_i;
  logic                  alu_valid_i;
  logic [REG_ADDR_W-1:0] alu_rd_i;
  logic [XLEN-1:0]       alu_data_i;
  logic                  mem_valid_i;
  logic                  mem_ready_o;
  logic [REG_ADDR_W-1:0] mem_rd_i;
  logic [XLEN-1:0]       mem_data_i;
  logic                  mdu_valid_i;
  logic                  mdu_ready_o;
  logic [REG_ADDR_W-1:0] mdu_rd_i;
  logic [XLEN-1:0]       mdu_data_i;
  logic [REG_ADDR_W-1:0] rd_addr_o;
  logic                  wr_en_o;
  logic [XLEN-1:0]       rd_data_o;
  logic [NREGS-1:0]      busy_o;

  int total;
  int bad;

  writeback_unit u_dut (
    .clk           (clk),
    .rst_sync      (rst_sync),
    .issue_valid_i (issue_valid_i),
    .issue_rd_i    (issue_rd_i),
    .alu_valid_i   (alu_valid_i),
    .alu_rd_i      (alu_rd_i),
    .alu_data_i    (alu_data_i),
    .mem_valid_i   (mem_valid_i),
    .mem_ready_o   (mem_ready_o),
    .mem_rd_i      (mem_rd_i),
    .mem_data_i    (mem_data_i),
    .mdu_valid_i   (mdu_valid_i),
    .mdu_ready_o   (mdu_ready_o),
    .mdu_rd_i      (mdu_rd_i),
    .mdu_data_i    (mdu_data_i),
    .rd_addr_o     (rd_addr_o),
    .wr_en_o       (wr_en_o),
    .rd_data_o     (rd_data_o),
    .busy_o        (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [REG_ADDR_W-1:0] rd);
    issue_valid_i = 1'b1;
    issue_rd_i    = rd;
    tick();
    issue_valid_i = 1'b0;
    issue_rd_i    = '0;
  endtask

  initial begin
    logic [REG_ADDR_W-1:0] mem_seq [4];
    logic [REG_ADDR_W-1:0] mdu_seq [3];
    int mi;
    int di;

    total = 0;
    bad   = 0;
    issue_valid_i = 0; issue_rd_i = '0;
    alu_valid_i = 0; alu_rd_i = '0; alu_data_i = '0;
    mem_valid_i = 0; mem_rd_i = '0; mem_data_i = '0;
    mdu_valid_i = 0; mdu_rd_i = '0; mdu_data_i = '0;

    // Reset
    rst_sync = 1'b1;
    tick();
    tick();
    chk("rst_wr_en", 64'(wr_en_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_addr", 64'(rd_addr_o), 64'd0);
    chk("rst_data", rd_data_o, 64'd0);
    rst_sync = 1'b0;
    tick();
    chk("rel_wr_en", 64'(wr_en_o), 64'd0);

    // Single ALU write to x5
    issue(5'd5);
    chk("iss5_busy", 64'(busy_o), 64'h20);
    alu_valid_i = 1; alu_rd_i = 5'd5; alu_data_i = 64'h1234;
    tick();
    alu_valid_i = 0;
    chk("alu5_wr_en", 64'(wr_en_o), 64'd1);
    chk("alu5_addr", 64'(rd_addr_o), 64'd5);
    chk("alu5_data", rd_data_o, 64'h1234);
    chk("alu5_busy_hold", 64'(busy_o), 64'h20);
    tick();
    chk("alu5_busy_clr", 64'(busy_o), 64'h0);
    chk("alu5_wr_idle", 64'(wr_en_o), 64'd0);

    // ALU wins over both slow sources, then MEM then MDU
    issue(5'd1);
    issue(5'd2);
    issue(5'd3);
    alu_valid_i = 1; alu_rd_i = 5'd1; alu_data_i = 64'hA1;
    mem_valid_i = 1; mem_rd_i = 5'd2; mem_data_i = 64'hB2;
    mdu_valid_i = 1; mdu_rd_i = 5'd3; mdu_data_i = 64'hC3;
    #1;
    chk("all3_mem_rdy", 64'(mem_ready_o), 64'd0);
    chk("all3_mdu_rdy", 64'(mdu_ready_o), 64'd0);
    tick();
    alu_valid_i = 0;
    chk("all3_alu_addr", 64'(rd_addr_o), 64'd1);
    chk("all3_alu_data", rd_data_o, 64'hA1);
    #1;
    chk("all3_mem_turn", 64'(mem_ready_o), 64'd1);
    chk("all3_mdu_wait", 64'(mdu_ready_o), 64'd0);
    tick();
    mem_valid_i = 0;
    chk("all3_mem_addr", 64'(rd_addr_o), 64'd2);
    chk("all3_mem_data", rd_data_o, 64'hB2);
    #1;
    chk("all3_mdu_rdy2", 64'(mdu_ready_o), 64'd1);
    tick();
    mdu_valid_i = 0;
    chk("all3_mdu_addr", 64'(rd_addr_o), 64'd3);
    chk("all3_mdu_data", rd_data_o, 64'hC3);
    tick();
    chk("all3_busy", 64'(busy_o), 64'h0);

    // MEM and MDU contending: grants alternate M,D,M,D,M,D then the last M
    mem_seq[0] = 5'd10; mem_seq[1] = 5'd12; mem_seq[2] = 5'd14; mem_seq[3] = 5'd16;
    mdu_seq[0] = 5'd11; mdu_seq[1] = 5'd13; mdu_seq[2] = 5'd15;
    for (int r = 10; r <= 16; r++) issue(5'(r));
    chk("rr_busy", 64'(busy_o), 64'h1FC00);
    mi = 0;
    di = 0;
    for (int c = 0; c < 7; c++) begin
      mem_valid_i = (mi < 4);
      mem_rd_i    = (mi < 4) ? mem_seq[mi] : 5'd0;
      mem_data_i  = 64'h100 + 64'(mem_rd_i);
      mdu_valid_i = (di < 3);
      mdu_rd_i    = (di < 3) ? mdu_seq[di] : 5'd0;
      mdu_data_i  = 64'h200 + 64'(mdu_rd_i);
      #1;
      chk($sformatf("rr%0d_mem_rdy", c), 64'(mem_ready_o), 64'(c % 2 == 0));
      chk($sformatf("rr%0d_mdu_rdy", c), 64'(mdu_ready_o), 64'(c % 2 == 1));
      tick();
      if (c % 2 == 0) begin
        chk($sformatf("rr%0d_addr", c), 64'(rd_addr_o), 64'(mem_seq[mi]));
        chk($sformatf("rr%0d_data", c), rd_data_o, 64'h100 + 64'(mem_seq[mi]));
        mi++;
      end else begin
        chk($sformatf("rr%0d_addr", c), 64'(rd_addr_o), 64'(mdu_seq[di]));
        chk($sformatf("rr%0d_data", c), rd_data_o, 64'h200 + 64'(mdu_seq[di]));
        di++;
      end
    end
    mem_valid_i = 0;
    mdu_valid_i = 0;
    tick();
    chk("rr_busy_done", 64'(busy_o), 64'h0);

    // MDU result to x0: handshake completes, no regfile write
    mdu_valid_i = 1; mdu_rd_i = 5'd0; mdu_data_i = 64'hFFFF;
    #1;
    chk("x0_mdu_rdy", 64'(mdu_ready_o), 64'd1);
    tick();
    mdu_valid_i = 0;
    chk("x0_wr_en", 64'(wr_en_o), 64'd0);
    chk("x0_busy", 64'(busy_o), 64'h0);

    // Reissue of x7 in its commit cycle keeps it busy
    issue(5'd7);
    alu_valid_i = 1; alu_rd_i = 5'd7; alu_data_i = 64'h77;
    tick();
    alu_valid_i = 0;
    chk("x7_commit", 64'(wr_en_o), 64'd1);
    issue(5'd7);
    chk("x7_set_wins", 64'(busy_o), 64'h80);

    // Reset while MEM is stalled behind the ALU
    issue(5'd8);
    alu_valid_i = 1; alu_rd_i = 5'd8; alu_data_i = 64'h88;
    mem_valid_i = 1; mem_rd_i = 5'd7; mem_data_i = 64'h99;
    #1;
    chk("stall_mem_rdy", 64'(mem_ready_o), 64'd0);
    tick();
    alu_valid_i = 0;
    rst_sync = 1'b1;
    tick();
    chk("midrst_wr_en", 64'(wr_en_o), 64'd0);
    chk("midrst_busy", 64'(busy_o), 64'h0);
    mem_valid_i = 0;
    rst_sync = 1'b0;
    tick();
    chk("postrst_wr_en", 64'(wr_en_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
